// File: rtl/sdram_s1_responder_if.sv
// Avalon-MM s1 bus between the core and the SDRAM-controller stand-in.
// Signal names match the Qsys controller port set so existing wiring maps one-to-one.
interface sdram_s1_responder_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] new_sdram_controller_0_s1_address;
    logic [3:0]        new_sdram_controller_0_s1_byteenable_n;
    logic              new_sdram_controller_0_s1_chipselect;
    logic [DATA_W-1:0] new_sdram_controller_0_s1_writedata;
    logic              new_sdram_controller_0_s1_read_n;
    logic              new_sdram_controller_0_s1_write_n;
    logic [DATA_W-1:0] new_sdram_controller_0_s1_readdata;
    logic              new_sdram_controller_0_s1_readdatavalid;
    logic              new_sdram_controller_0_s1_waitrequest;

    modport master (
        output new_sdram_controller_0_s1_address,
        output new_sdram_controller_0_s1_byteenable_n,
        output new_sdram_controller_0_s1_chipselect,
        output new_sdram_controller_0_s1_writedata,
        output new_sdram_controller_0_s1_read_n,
        output new_sdram_controller_0_s1_write_n,
        input  new_sdram_controller_0_s1_readdata,
        input  new_sdram_controller_0_s1_readdatavalid,
        input  new_sdram_controller_0_s1_waitrequest
    );

    modport slave (
        input  new_sdram_controller_0_s1_address,
        input  new_sdram_controller_0_s1_byteenable_n,
        input  new_sdram_controller_0_s1_chipselect,
        input  new_sdram_controller_0_s1_writedata,
        input  new_sdram_controller_0_s1_read_n,
        input  new_sdram_controller_0_s1_write_n,
        output new_sdram_controller_0_s1_readdata,
        output new_sdram_controller_0_s1_readdatavalid,
        output new_sdram_controller_0_s1_waitrequest
    );
endinterface

// File: rtl/sdram_s1_responder.sv
// Stand-in for the Qsys SDRAM controller s1 slave: on-chip word RAM behind a
// default-high waitrequest and a fixed-latency pipelined read return.
module sdram_s1_responder #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 25,
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned READ_LATENCY = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sdram_s1_responder_if.slave  s1,
    output logic                 o_oob_err,
    output logic                 o_proto_err,
    output logic [15:0]          o_rd_count,
    output logic [15:0]          o_wr_count
);
    localparam int unsigned Depth   = 1 << MEM_AW;
    localparam logic [3:0]  CntLast = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCount, StAccept} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              waitreq_q;
    logic              oob_q, proto_q;
    logic [15:0]       rd_cnt_q, wr_cnt_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [READ_LATENCY];
    logic [DATA_W-1:0] mem_q [Depth];

    logic              cs, rd_req, wr_req, cmd_valid, cmd_bad, rd_acc, wr_acc, oob;
    logic [MEM_AW-1:0] idx;
    logic [3:0]        be_n;

    assign cs        = s1.new_sdram_controller_0_s1_chipselect;
    assign rd_req    = cs & ~s1.new_sdram_controller_0_s1_read_n &
                       s1.new_sdram_controller_0_s1_write_n;
    assign wr_req    = cs & s1.new_sdram_controller_0_s1_read_n &
                       ~s1.new_sdram_controller_0_s1_write_n;
    assign cmd_bad   = cs & ~s1.new_sdram_controller_0_s1_read_n &
                       ~s1.new_sdram_controller_0_s1_write_n;
    assign cmd_valid = rd_req | wr_req;
    // waitrequest is low only while in StAccept, so that state alone qualifies the accept
    assign rd_acc    = (state_q == StAccept) & rd_req;
    assign wr_acc    = (state_q == StAccept) & wr_req;
    assign idx       = s1.new_sdram_controller_0_s1_address[MEM_AW-1:0];
    assign oob       = |s1.new_sdram_controller_0_s1_address[ADDR_W-1:MEM_AW];
    assign be_n      = s1.new_sdram_controller_0_s1_byteenable_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            waitreq_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (WAIT_CYCLES == 1) begin
                            state_q   <= StAccept;
                            waitreq_q <= 1'b0;
                        end else begin
                            state_q <= StCount;
                            cnt_q   <= 4'd1;
                        end
                    end
                end
                StCount: begin
                    if (!cmd_valid) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StAccept;
                        waitreq_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StAccept: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    waitreq_q <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    waitreq_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            oob_q    <= 1'b0;
            proto_q  <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (cmd_bad) proto_q <= 1'b1;
            if ((rd_acc || wr_acc) && oob) oob_q <= 1'b1;
            if (rd_acc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (wr_acc && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    // Data stages only advance with their valid bit, so the last stage holds its value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) dat_q[0] <= mem_q[idx];
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            for (int k = 0; k < 4; k++) begin
                if (!be_n[k]) mem_q[idx][8*k +: 8] <= s1.new_sdram_controller_0_s1_writedata[8*k +: 8];
            end
        end
    end

    assign s1.new_sdram_controller_0_s1_readdata      = dat_q[READ_LATENCY-1];
    assign s1.new_sdram_controller_0_s1_readdatavalid = vld_q[READ_LATENCY-1];
    assign s1.new_sdram_controller_0_s1_waitrequest   = waitreq_q;
    assign o_oob_err   = oob_q;
    assign o_proto_err = proto_q;
    assign o_rd_count  = rd_cnt_q;
    assign o_wr_count  = wr_cnt_q;
endmodule

// File: tb/tb_sdram_s1_responder.sv
// Directed bench for sdram_s1_responder: a cycle model built from accept-streak,
// byte-lane and delay-queue rules is compared every cycle, plus literal spot checks.
module tb_sdram_s1_responder;
    localparam int unsigned W   = 2;
    localparam int unsigned RL  = 3;
    localparam int unsigned AW  = 25;
    localparam int unsigned MAW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [3:0]    be_n = 4'hF;
    logic          cs = 1'b0;
    logic [31:0]   wdata = '0;
    logic          rd_n = 1'b1;
    logic          wr_n = 1'b1;
    logic [31:0]   rdata;
    logic          rdv, wreq, oob_err, proto_err;
    logic [15:0]   rd_cnt, wr_cnt;

    sdram_s1_responder_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    assign bus.new_sdram_controller_0_s1_address      = addr;
    assign bus.new_sdram_controller_0_s1_byteenable_n = be_n;
    assign bus.new_sdram_controller_0_s1_chipselect   = cs;
    assign bus.new_sdram_controller_0_s1_writedata    = wdata;
    assign bus.new_sdram_controller_0_s1_read_n       = rd_n;
    assign bus.new_sdram_controller_0_s1_write_n      = wr_n;
    assign rdata = bus.new_sdram_controller_0_s1_readdata;
    assign rdv   = bus.new_sdram_controller_0_s1_readdatavalid;
    assign wreq  = bus.new_sdram_controller_0_s1_waitrequest;

    sdram_s1_responder #(
        .DATA_W(32), .ADDR_W(AW), .MEM_AW(MAW), .WAIT_CYCLES(W), .READ_LATENCY(RL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .s1(bus),
        .o_oob_err(oob_err),
        .o_proto_err(proto_err),
        .o_rd_count(rd_cnt),
        .o_wr_count(wr_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int acc_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a command accepts on its (W+1)-th consecutive valid edge; reads return RL-1
    // edges after that accept edge, in order.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t         q[$];
    rd_t         item;
    logic [31:0] mem_m [int];
    logic [31:0] word;
    logic [31:0] m_rdata = '0;
    logic [15:0] m_rd = '0, m_wr = '0;
    logic        m_oob = 1'b0, m_proto = 1'b0, m_rdv = 1'b0, m_wreq = 1'b1, m_valid;
    int          streak = 0;
    int          idx;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            streak = 0;
            q.delete();
            m_rd = '0; m_wr = '0; m_oob = 1'b0; m_proto = 1'b0;
            m_rdv = 1'b0; m_wreq = 1'b1; m_rdata = '0;
        end else begin
            m_valid = cs && (rd_n != wr_n);
            if (cs && !rd_n && !wr_n) m_proto = 1'b1;
            if (m_valid) begin
                streak++;
                if (streak == W + 1) begin
                    streak = 0;
                    idx = int'(addr[MAW-1:0]);
                    word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                    if ((addr >> MAW) != 0) m_oob = 1'b1;
                    if (!rd_n) begin
                        item.due = cyc + RL - 1;
                        item.data = word;
                        q.push_back(item);
                        if (m_rd != 16'hFFFF) m_rd++;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            if (!be_n[k]) word[8*k +: 8] = wdata[8*k +: 8];
                        mem_m[idx] = word;
                        if (m_wr != 16'hFFFF) m_wr++;
                    end
                end
            end else begin
                streak = 0;
            end
            m_wreq = (streak != W);
            m_rdv = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_rdv = 1'b1;
                m_rdata = q[0].data;
                void'(q.pop_front());
            end
        end
        #1;
        chk("waitrequest", 32'(wreq), 32'(m_wreq));
        chk("readdatavalid", 32'(rdv), 32'(m_rdv));
        chk("readdata", rdata, m_rdata);
        chk("rd_count", 32'(rd_cnt), 32'(m_rd));
        chk("wr_count", 32'(wr_cnt), 32'(m_wr));
        chk("oob_err", 32'(oob_err), 32'(m_oob));
        chk("proto_err", 32'(proto_err), 32'(m_proto));
        if (rdv) pulses++;
    end

    // Present a command, check the wait length, hold through the accept edge, then drop it.
    task automatic cmd(input bit is_wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        int n;
        n = 0;
        @(negedge clk);
        cs = 1'b1; addr = a; wdata = d; be_n = be; rd_n = is_wr; wr_n = !is_wr;
        do begin
            @(posedge clk); #1; n++;
        end while (wreq && n < 40);
        chk("wait_cycles", n, W);
        @(posedge clk); #1;
        acc_edge = cyc;
        @(negedge clk);
        cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; be_n = 4'hF;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        int n;
        n = 0;
        cmd(1'b0, a, 32'h0, 4'hF);
        while (!rdv && n < 40) begin
            @(posedge clk); #1; n++;
        end
        // readdatavalid is visible right after edge (accept + RL - 1)
        chk({name, "_latency"}, cyc - acc_edge, RL - 1);
        chk(name, rdata, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_waitrequest", 32'(wreq), 1);
        chk("rst_rdv", 32'(rdv), 0);
        chk("rst_rd_count", 32'(rd_cnt), 0);
        chk("rst_wr_count", 32'(wr_cnt), 0);
        chk("rst_oob", 32'(oob_err), 0);
        chk("rst_proto", 32'(proto_err), 0);

        cmd(1'b1, 25'h005, 32'hDEADBEEF, 4'h0);
        rd(25'h005, 32'hDEADBEEF, "wr_rd");
        chk("wr_rd_wr_count", 32'(wr_cnt), 1);
        chk("wr_rd_rd_count", 32'(rd_cnt), 1);

        cmd(1'b1, 25'h007, 32'h11223344, 4'h0);
        cmd(1'b1, 25'h007, 32'hAABBCCDD, 4'b1010);
        rd(25'h007, 32'h11BB33DD, "byte_en");

        // Withdrawn read: one edge of validity, then chipselect drops.
        @(negedge clk);
        cs = 1'b1; addr = 25'h007; rd_n = 1'b0;
        @(negedge clk);
        chk("withdraw_wait", 32'(wreq), 1);
        cs = 1'b0; rd_n = 1'b1;
        repeat (2) @(negedge clk);
        rd(25'h007, 32'h11BB33DD, "withdraw");
        chk("withdraw_rd_count", 32'(rd_cnt), 3);
        chk("withdraw_pulses", pulses, 3);

        cmd(1'b1, 25'h403, 32'h0000CAFE, 4'h0);
        rd(25'h003, 32'h0000CAFE, "alias");
        chk("alias_oob", 32'(oob_err), 1);

        @(negedge clk);
        cs = 1'b1; addr = 25'h003; rd_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("proto_wait", 32'(wreq), 1);
        end
        cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        chk("proto_flag", 32'(proto_err), 1);
        chk("proto_rd_count", 32'(rd_cnt), 4);
        chk("proto_wr_count", 32'(wr_cnt), 4);

        // Reset one cycle after a read accept must swallow its return.
        cmd(1'b0, 25'h005, 32'h0, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid_pulses", pulses, 4);
        chk("rst_mid_rd_count", 32'(rd_cnt), 0);
        chk("rst_mid_oob", 32'(oob_err), 0);
        chk("rst_mid_proto", 32'(proto_err), 0);
        rd(25'h005, 32'hDEADBEEF, "retained");

        cmd(1'b1, 25'h005, 32'h12345678, 4'hF);
        rd(25'h005, 32'hDEADBEEF, "be_none");
        chk("be_none_wr_count", 32'(wr_cnt), 1);
        chk("be_none_rd_count", 32'(rd_cnt), 2);

        repeat (6) @(negedge clk);
        chk("total_pulses", pulses, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
